ramsim_mp_timing_model: RTL and testbench
=========================================

# ramsim_mp_timing_model

Parametrised, multi-port, synthesizable memory timing model that replaces per-port external model calls with an in-RTL word array, a fixed-latency pipeline and bounded outstanding-request tracking. It sits between the bus masters under test and the simulated memory. Up to one request per cycle is accepted from N ports by round-robin arbitration. Tagged responses return in acceptance order on a single channel with back-pressure.

## Interface
- NUM_PORTS, 2: number of request ports (1..8).
- ADDR_W, 16: word-address width.
- DATA_W, 64: data width.
- DEPTH, 1024: number of words; addresses at or above DEPTH are out of range.
- LATENCY, 4: cycles from acceptance to response-queue entry (≥1).
- MAX_OUT, 8: outstanding-request limit (power of two, ≥2).
- PID_W = max(1, clog2(NUM_PORTS)): derived.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port grant (combinational).
- req_we  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_W  flat, port i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  flat, same packing.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_pid  out  PID_W  originating port.
- resp_we  out  1  response is a write acknowledge.
- resp_err  out  1  address was out of range.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.

## Operation
- Credit counter `outstanding` (width clog2(MAX_OUT)+1) = requests in pipeline + response queue.
- Arbiter: if outstanding < MAX_OUT, grant the first valid port at or after rr_ptr (wrapping). Exactly one req_ready bit high, otherwise none. req_ready depends only on req_valid, rr_ptr and outstanding, never on resp_ready.
- Acceptance = req_valid[i] && req_ready[i]. rr_ptr <= (i+1) mod NUM_PORTS. rr_ptr is unchanged when nothing is granted.
- Write accept: array[addr] <= wdata on the same edge. Read accept: data is sampled from the array on the same edge. A later write never alters an already-accepted read.
- Out of range: the write is dropped and the read returns 0. The response carries resp_err=1.
- Accepted entry {pid, we, err, rdata} shifts through a LATENCY-stage valid-tagged pipeline, then pushes into a MAX_OUT-deep FIFO.
- FIFO head drives resp_*. The pop occurs on resp_valid && resp_ready.
- Counter: +1 on accept, −1 on pop, unchanged on both. The FIFO cannot overflow by construction. An overflow attempt is an assertion failure.
- Array contents are not cleared by reset (X in sim).

## Timing
- Reset values: req_ready=0 (outstanding forced 0 but grant held low during reset), resp_valid=0, resp_pid=0, resp_we=0, resp_err=0, resp_rdata=0. rr_ptr=0, pipeline and FIFO empty.
- Reset mid-operation discards all in-flight entries. No responses are produced for them.
- Request accepted at edge T gives resp_valid=1 in the cycle after edge T+LATENCY when the queue ahead is empty.
- Throughput: 1 accept and 1 response per cycle sustained.
- resp_valid held with stable payload until popped.
- At outstanding == MAX_OUT, all req_ready are 0. A pop at edge E allows a grant in the cycle after E.

## Structure
- Package ramsim_pkg: resp_entry_t struct {pid, we, err, rdata} (parametrised widths via localparam defaults), clog2/max helper function, PID_W derivation.
- Sub-module ramsim_rr_arbiter (NUM_PORTS, combinational grant plus registered rr_ptr, enable input = credit available).
- Pipeline, FIFO, counter and array stay in the top module.

## Test plan
- Single port 0: write addr 5 = 0xDEAD, then read addr 5 → write ack (we=1, pid=0) at T+4 and read response rdata=0xDEAD at T+5.
- Ports 0 and 1 both valid continuously → grants alternate 0,1,0,1. The responses' pid sequence matches.
- resp_ready=0, 10 reads from port 1 → exactly 8 accepted, then req_ready=0. One pop → one further accept the next cycle.
- Read addr 2000 (DEPTH 1024) → resp_err=1, rdata=0. Write addr 2000 followed by reading addr 2000 mod 1024 → original data unchanged.
- Read addr 7 accepted at T, write addr 7 = 0x1 at T+1 → read response returns the old value.
- Assert rst_n=0 with 3 requests in flight → outputs go to reset values immediately. After release, no stale responses appear and the first new request behaves per the latency rule.

Source files
------------

// File: rtl/ramsim_pkg.sv
// rtl/ramsim_pkg.sv - shared types and elaboration helpers for the RAM timing model
package ramsim_pkg;

    localparam int RESP_PID_W  = 3;
    localparam int RESP_DATA_W = 64;

    typedef struct packed {
        logic [RESP_PID_W-1:0]  pid;
        logic                   we;
        logic                   err;
        logic [RESP_DATA_W-1:0] rdata;
    } resp_entry_t;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int pid_width(input int num_ports);
        return max_f(1, clog2_f(num_ports));
    endfunction

endpackage

// File: rtl/ramsim_rr_arbiter.sv
// rtl/ramsim_rr_arbiter.sv - round-robin single-grant arbiter with registered pointer
module ramsim_rr_arbiter
    import ramsim_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    localparam int PID_W = pid_width(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_PORTS-1:0] req_valid,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 grant_any,
    output logic [PID_W-1:0]     grant_idx
);

    logic [PID_W-1:0] rr_ptr_q;
    logic [PID_W-1:0] rr_ptr_d;

    // Grant the first valid port at or after rr_ptr, wrapping; nothing when disabled.
    always_comb begin
        int p;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        p         = 0;
        if (en) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                p = int'(rr_ptr_q) + k;
                if (p >= NUM_PORTS) p = p - NUM_PORTS;
                if (!grant_any && req_valid[p]) begin
                    grant_any = 1'b1;
                    grant_idx = PID_W'(p);
                    grant[p]  = 1'b1;
                end
            end
        end
    end

    // A grant is always an acceptance, so the pointer moves past the winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == PID_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PID_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/ramsim_mp_timing_model.sv
// rtl/ramsim_mp_timing_model.sv - multi-port word array with fixed-latency in-order responses
module ramsim_mp_timing_model
    import ramsim_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = RESP_DATA_W,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 4,
    parameter int MAX_OUT   = 8,
    localparam int PID_W = pid_width(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [PID_W-1:0]            resp_pid,
    output logic                        resp_we,
    output logic                        resp_err,
    output logic [DATA_W-1:0]           resp_rdata
);

    localparam int CNT_W = clog2_f(MAX_OUT) + 1;
    localparam int PTR_W = clog2_f(MAX_OUT);
    localparam int IDX_W = max_f(1, clog2_f(DEPTH));
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [PID_W-1:0]  pid;
        logic              we;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } entry_t;

    logic [NUM_PORTS-1:0] grant;
    logic                 accept;
    logic [PID_W-1:0]     grant_idx;
    logic                 arb_en;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 in_range;
    logic [IDX_W-1:0]     mem_idx;
    logic [DATA_W-1:0]    rd_word;
    entry_t               acc_entry;
    entry_t               head;
    logic                 push;
    logic                 pop;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    entry_t             pipe_q [LATENCY];
    entry_t             pipe_d [LATENCY];
    entry_t             fifo_q [MAX_OUT];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;

    // Credit gate: no grant while in reset or while the response path is fully booked.
    assign arb_en = rst_n && (outstanding_q < CNT_W'(MAX_OUT));

    ramsim_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (arb_en),
        .req_valid (req_valid),
        .grant     (grant),
        .grant_any (accept),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;

    // Route the granted port's request fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_range = {1'b0, sel_addr} < DEPTH_A;
    assign mem_idx  = sel_addr[IDX_W-1:0];
    assign rd_word  = mem_q[mem_idx];

    // Build the response entry; reads capture array data now, before any later write.
    always_comb begin
        acc_entry.pid   = grant_idx;
        acc_entry.we    = sel_we;
        acc_entry.err   = !in_range;
        acc_entry.rdata = (!sel_we && in_range) ? rd_word : '0;
    end

    // Word array; out-of-range writes are dropped, contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && sel_we && in_range) mem_q[mem_idx] <= sel_wdata;
    end

    // Fixed-latency shift pipeline from acceptance to the response queue.
    always_comb begin
        pipe_vld_d[0] = accept;
        pipe_d[0]     = acc_entry;
        for (int s = 1; s < LATENCY; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_d[s]     = pipe_q[s-1];
        end
    end

    // Pipeline valid bits reset so in-flight entries are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_vld_q <= '0;
        else        pipe_vld_q <= pipe_vld_d;
    end

    // Pipeline payload carries no reset; only the valid tags matter.
    always_ff @(posedge clk) begin
        for (int s = 0; s < LATENCY; s++) pipe_q[s] <= pipe_d[s];
    end

    assign push       = pipe_vld_q[LATENCY-1];
    assign resp_valid = (fifo_cnt_q != '0);
    assign pop        = resp_valid && resp_ready;
    assign head       = fifo_q[rd_ptr_q];

    // Response outputs read zero whenever the queue is empty.
    always_comb begin
        resp_pid   = resp_valid ? head.pid   : '0;
        resp_we    = resp_valid ? head.we    : 1'b0;
        resp_err   = resp_valid ? head.err   : 1'b0;
        resp_rdata = resp_valid ? head.rdata : '0;
    end

    // Queue pointers, occupancy and the outstanding-credit counter.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        outstanding_d = outstanding_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            outstanding_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Queue storage; the credit limit guarantees a free slot on every push.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= pipe_q[LATENCY-1];
        if (rst_n) begin
            assert (!(push && !pop && fifo_cnt_q == CNT_W'(MAX_OUT)))
                else $error("response queue overflow");
        end
    end

endmodule

// File: tb/tb_ramsim_mp_timing_model.sv
// tb/tb_ramsim_mp_timing_model.sv - scoreboard bench for the multi-port RAM timing model
module tb_ramsim_mp_timing_model;

    localparam int NP = 2;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [0:0]    pid;
        logic          we;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    req_we;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [0:0]       resp_pid;
    logic             resp_we;
    logic             resp_err;
    logic [DW-1:0]    resp_rdata;

    rsp_t          exp_q[$];
    rsp_t          rsp_log[$];
    logic [DW-1:0] model_mem [DEPTH];
    int            n_checks = 0;
    int            n_fail = 0;

    ramsim_mp_timing_model #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .LATENCY(4), .MAX_OUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pid(resp_pid),
        .resp_we(resp_we), .resp_err(resp_err), .resp_rdata(resp_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard: push expectations on acceptance, compare on every pop.
    always @(negedge clk) begin
        rsp_t e;
        rsp_t got;
        int   a;
        n_checks++;
        if ($countones(req_ready) > 1) begin
            n_fail++;
            $display("FAIL ready_onehot: req_ready=%b, required at most one bit", req_ready);
        end
        for (int i = 0; i < NP; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                a       = int'(req_addr[i*AW +: AW]);
                e.pid   = 1'(i);
                e.we    = req_we[i];
                e.err   = (a >= DEPTH);
                e.rdata = (!e.we && !e.err) ? model_mem[a] : '0;
                if (e.we && !e.err) model_mem[a] = req_wdata[i*DW +: DW];
                exp_q.push_back(e);
            end
        end
        if (resp_valid && resp_ready) begin
            got.pid   = resp_pid;
            got.we    = resp_we;
            got.err   = resp_err;
            got.rdata = resp_rdata;
            rsp_log.push_back(got);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pid=%0d we=%0d err=%0d rdata=%h, required no response",
                         got.pid, got.we, got.err, got.rdata);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL sb_payload: got pid=%0d we=%0d err=%0d rdata=%h, required pid=%0d we=%0d err=%0d rdata=%h",
                             got.pid, got.we, got.err, got.rdata, e.pid, e.we, e.err, e.rdata);
                end
            end
        end
    end

    // Present one request on port p until it is granted; returns 1ns after the accepting edge.
    task automatic do_req(input int p, input logic we, input int addr, input logic [DW-1:0] d);
        int w;
        w = 0;
        req_valid[p]            = 1'b1;
        req_we[p]               = we;
        req_addr[p*AW +: AW]    = AW'(addr);
        req_wdata[p*DW +: DW]   = d;
        @(negedge clk);
        while (!req_ready[p] && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (!req_ready[p]) begin
            n_fail++;
            $display("FAIL req_timeout: port %0d req_ready=%b, required grant", p, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        resp_ready = 1'b1;
        while ((exp_q.size() != 0 || resp_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d responses pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = '1;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        #3;
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b, required 00", req_ready);
        end
        n_checks++;
        if ({resp_valid, resp_pid, resp_we, resp_err} !== 4'b0 || resp_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: valid=%b pid=%b we=%b err=%b rdata=%h, required all 0",
                     resp_valid, resp_pid, resp_we, resp_err, resp_rdata);
        end
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_port();
        do_req(0, 1'b1, 5, 64'hDEAD);
        do_req(0, 1'b0, 5, '0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_early: cycle T+%0d resp_valid=%b, required 0", k, resp_valid);
            end
        end
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_we !== 1'b1 || resp_pid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== '0) begin
            n_fail++;
            $display("FAIL write_ack: valid=%b we=%b pid=%b err=%b rdata=%h, required 1 1 0 0 0",
                     resp_valid, resp_we, resp_pid, resp_err, resp_rdata);
        end
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_we !== 1'b0 || resp_rdata !== 64'hDEAD) begin
            n_fail++;
            $display("FAIL read_data: valid=%b we=%b rdata=%h, required 1 0 dead",
                     resp_valid, resp_we, resp_rdata);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] exp_g;
        rsp_log.delete();
        req_we = '0;
        req_addr = {16'd5, 16'd5};
        req_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_g = (c % 2 == 0) ? 2'b10 : 2'b01;
            n_checks++;
            if (req_ready !== exp_g) begin
                n_fail++;
                $display("FAIL rr_grant: cycle %0d req_ready=%b, required %b", c, req_ready, exp_g);
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();
        n_checks++;
        if (rsp_log.size() != 8) begin
            n_fail++;
            $display("FAIL rr_count: %0d responses, required 8", rsp_log.size());
        end else begin
            for (int c = 0; c < 8; c++) begin
                n_checks++;
                if (rsp_log[c].pid !== ((c % 2 == 0) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL rr_pid: response %0d pid=%b, required %0d", c, rsp_log[c].pid, (c % 2 == 0) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int   acc;
        rsp_t held;
        rsp_log.delete();
        acc = 0;
        held = '0;
        resp_ready = 1'b0;
        req_we[1] = 1'b0;
        req_addr[AW +: AW] = 16'd5;
        req_valid[1] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (req_valid[1] && req_ready[1]) acc++;
            if (c == 10) held = '{resp_pid, resp_we, resp_err, resp_rdata};
        end
        n_checks++;
        if (acc != 8) begin
            n_fail++;
            $display("FAIL bp_accepts: %0d accepted, required 8", acc);
        end
        n_checks++;
        if (req_ready !== 2'b00 || resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: req_ready=%b resp_valid=%b, required 00 and 1", req_ready, resp_valid);
        end
        n_checks++;
        if (held !== rsp_t'({resp_pid, resp_we, resp_err, resp_rdata})) begin
            n_fail++;
            $display("FAIL bp_stable: head changed from %h to %h while stalled",
                     held, {resp_pid, resp_we, resp_err, resp_rdata});
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_early_grant: req_ready[1]=%b before pop, required 0", req_ready[1]);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_regrant: req_ready[1]=%b after pop, required 1", req_ready[1]);
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        drain();
        n_checks++;
        if (rsp_log.size() != 9) begin
            n_fail++;
            $display("FAIL bp_total: %0d responses, required 9", rsp_log.size());
        end
    endtask

    task automatic test_out_of_range();
        rsp_log.delete();
        do_req(0, 1'b1, 976, 64'hCAFE);
        do_req(0, 1'b0, 2000, '0);
        do_req(0, 1'b1, 2000, 64'h1234);
        do_req(0, 1'b0, 976, '0);
        drain();
        n_checks++;
        if (rsp_log.size() != 4) begin
            n_fail++;
            $display("FAIL oor_count: %0d responses, required 4", rsp_log.size());
        end else begin
            n_checks++;
            if (rsp_log[1].err !== 1'b1 || rsp_log[1].rdata !== '0) begin
                n_fail++;
                $display("FAIL oor_read: err=%b rdata=%h, required 1 0", rsp_log[1].err, rsp_log[1].rdata);
            end
            n_checks++;
            if (rsp_log[2].err !== 1'b1 || rsp_log[2].we !== 1'b1) begin
                n_fail++;
                $display("FAIL oor_write: err=%b we=%b, required 1 1", rsp_log[2].err, rsp_log[2].we);
            end
            n_checks++;
            if (rsp_log[3].err !== 1'b0 || rsp_log[3].rdata !== 64'hCAFE) begin
                n_fail++;
                $display("FAIL oor_alias: err=%b rdata=%h, required 0 cafe", rsp_log[3].err, rsp_log[3].rdata);
            end
        end
    endtask

    task automatic test_read_then_write();
        do_req(1, 1'b1, 7, 64'h77);
        drain();
        rsp_log.delete();
        do_req(1, 1'b0, 7, '0);
        do_req(1, 1'b1, 7, 64'h1);
        do_req(1, 1'b0, 7, '0);
        drain();
        n_checks++;
        if (rsp_log.size() != 3) begin
            n_fail++;
            $display("FAIL rw_count: %0d responses, required 3", rsp_log.size());
        end else begin
            n_checks++;
            if (rsp_log[0].rdata !== 64'h77) begin
                n_fail++;
                $display("FAIL rw_old_value: rdata=%h, required 77", rsp_log[0].rdata);
            end
            n_checks++;
            if (rsp_log[2].rdata !== 64'h1) begin
                n_fail++;
                $display("FAIL rw_new_value: rdata=%h, required 1", rsp_log[2].rdata);
            end
        end
    endtask

    task automatic test_reset_midflight();
        rsp_log.delete();
        do_req(0, 1'b1, 10, 64'hA);
        do_req(0, 1'b1, 11, 64'hB);
        do_req(0, 1'b0, 5, '0);
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b00 || resp_valid !== 1'b0 || resp_pid !== 1'b0 || resp_we !== 1'b0 ||
            resp_err !== 1'b0 || resp_rdata !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: ready=%b valid=%b pid=%b we=%b err=%b rdata=%h, required reset values",
                     req_ready, resp_valid, resp_pid, resp_we, resp_err, resp_rdata);
        end
        exp_q.delete();
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_resp: cycle %0d resp_valid=%b, required 0", c, resp_valid);
            end
        end
        @(posedge clk);
        #1;
        do_req(0, 1'b0, 5, '0);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_early: cycle T+%0d resp_valid=%b, required 0", k, resp_valid);
            end
        end
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'hDEAD || resp_pid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_latency: valid=%b rdata=%h pid=%b, required 1 dead 0",
                     resp_valid, resp_rdata, resp_pid);
        end
        @(posedge clk);
        #1;
        drain();
        n_checks++;
        if (rsp_log.size() != 1) begin
            n_fail++;
            $display("FAIL post_reset_count: %0d responses, required 1", rsp_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_out_of_range();
        test_read_then_write();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
